// File: rtl/poker_pkg.sv
// Shared card, rank and dealer-state definitions for the dealer and the hand evaluator.
package poker_pkg;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  localparam logic [3:0]  RANK_MIN  = 4'h2;
  localparam logic [3:0]  RANK_ACE  = 4'he;
  localparam int          HAND_SIZE = 5;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } dealer_state_t;

  // Ordering key: rank dominates, suit breaks ties between equal ranks.
  function automatic logic [5:0] sort_key(input card_t c);
    return {c.rank, c.suit};
  endfunction

endpackage

// File: rtl/hand_dealer_if.sv
// Request/seed/handshake bundle between a hand consumer and the hand dealer.
interface hand_dealer_if;
  import poker_pkg::*;

  logic        deal_req;
  logic        seed_load;
  logic [15:0] seed;
  logic        hand_ready;
  logic        hand_valid;
  logic        busy;
  card_t       card0;
  card_t       card1;
  card_t       card2;
  card_t       card3;
  card_t       card4;

  modport master (
    output deal_req, seed_load, seed, hand_ready,
    input  hand_valid, busy, card0, card1, card2, card3, card4
  );

  modport slave (
    input  deal_req, seed_load, seed, hand_ready,
    output hand_valid, busy, card0, card1, card2, card3, card4
  );

endinterface

// File: rtl/hand_lfsr.sv
// Free-running 16-bit Galois LFSR; a loaded seed of zero is replaced by LFSR_SEED
// because the all-zero state would lock the register.
module hand_lfsr
  import poker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    if (seed_load) begin
      lfsr_d = (seed == 16'h0000) ? LFSR_SEED : seed;
    end else begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/hand_dealer.sv
// Deals one five-card hand per request: candidates come from the LFSR, invalid ranks
// and repeats are skipped, and accepted cards are insertion-sorted into card0..card4.
module hand_dealer
  import poker_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  hand_dealer_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DRAW = DRAW;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]  state_q, state_d;
  logic [63:0] used_q, used_d;
  logic [2:0]  count_q, count_d;
  card_t [4:0] cards_q, cards_d;

  logic [15:0] lfsr;
  logic        unused_lfsr_hi;
  card_t       cand;
  logic        cand_ok;
  logic [2:0]  slot;
  card_t [4:0] shifted;
  card_t [4:0] inserted;

  hand_lfsr u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (bus.seed_load),
    .seed      (bus.seed),
    .lfsr      (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:6];
  assign cand    = card_t'(lfsr[5:0]);
  assign cand_ok = (cand.rank >= RANK_MIN) && (cand.rank <= RANK_ACE) && !used_q[lfsr[5:0]];

  // Slot = how many already-filled entries sort below the candidate.
  always_comb begin
    slot = 3'd0;
    for (int i = 0; i < HAND_SIZE; i++) begin
      if ((3'(i) < count_q) && (sort_key(cards_q[i]) < sort_key(cand))) begin
        slot = slot + 3'd1;
      end
    end
  end

  assign shifted = {cards_q[3:0], card_t'(6'h00)};

  always_comb begin
    for (int i = 0; i < HAND_SIZE; i++) begin
      if (3'(i) < slot) begin
        inserted[i] = cards_q[i];
      end else if (3'(i) == slot) begin
        inserted[i] = cand;
      end else begin
        inserted[i] = shifted[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    count_d = count_q;
    cards_d = cards_q;
    case (state_q)
      S_IDLE: begin
        if (bus.deal_req) begin
          state_d = S_DRAW;
          used_d  = '0;
          count_d = '0;
          cards_d = '0;
        end
      end
      S_DRAW: begin
        if (cand_ok) begin
          cards_d             = inserted;
          used_d[lfsr[5:0]]   = 1'b1;
          count_d             = count_q + 3'd1;
          if (count_q == 3'(HAND_SIZE - 1)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.hand_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      used_q  <= '0;
      count_q <= '0;
      cards_q <= '0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      count_q <= count_d;
      cards_q <= cards_d;
    end
  end

  assign bus.hand_valid = (state_q == S_HOLD);
  assign bus.busy       = (state_q == S_DRAW);
  assign bus.card0      = cards_q[0];
  assign bus.card1      = cards_q[1];
  assign bus.card2      = cards_q[2];
  assign bus.card3      = cards_q[3];
  assign bus.card4      = cards_q[4];

endmodule

// File: doc/hand_dealer.md
# hand_dealer

- Deals one random five-card poker hand per request.
- Draws candidate cards from a free-running 16-bit LFSR and rejects invalid encodings and duplicates.
- Insertion-sorts accepted cards by ascending rank.
- Presents the sorted hand on a valid/ready handshake, in the card0 (lowest) .. card4 (highest) order the hand evaluator consumes.

## Interface
- LFSR_SEED, 16'hACE1, LFSR value at reset; also replaces a loaded seed of zero.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- deal_req  in  1  request a new hand; sampled only in IDLE.
- seed_load  in  1  load LFSR from seed on this edge.
- seed  in  16  LFSR seed value.
- hand_ready  in  1  consumer accepts the presented hand.
- hand_valid  out  1  sorted hand is present on card0..card4.
- busy  out  1  high in DRAW.
- card0..card4  out  6 each  cards, {suit[5:4], rank[3:0]}; rank 2..14, where 14 (4'he) is the ace.

## Operation
- **LFSR:** 16-bit Galois, taps 16'hB400, shifts every cycle in all states.
  - seed_load has priority over the shift. It loads seed, or LFSR_SEED if seed==0.
  - Candidate each cycle = lfsr[5:0].
- **Candidate acceptance:** accepted iff rank in 4'h2..4'he and used[candidate]==0.
- **FSM states:** IDLE, DRAW, HOLD.
- **IDLE:** deal_req=1 → DRAW. On that edge:
  - clear the 64-bit used mask;
  - clear count (3 bits);
  - clear all card registers to 6'h00.
- **DRAW:** each cycle with an accepted candidate:
  - insert it into the sorted array, shifting larger entries up one slot;
  - set used[candidate];
  - increment count.
  - Rejected candidates leave all state unchanged.
  - When count reaches 5 (on the edge of the fifth insertion) → HOLD.
- **Sort order:** ascending rank; equal rank cannot occur with equal suit, so ties break by ascending suit.
- **Insertion slot:** slot index = number of filled entries whose key {rank,suit} is below the candidate's key. The array then forms ordering card0..card4 after five inserts.
- **HOLD:**
  - hand_valid=1; card outputs frozen.
  - hand_valid && hand_ready → IDLE on that edge.
- **Ignored inputs:**
  - deal_req outside IDLE is ignored and not queued, including a deal_req coinciding with the HOLD handshake.
  - hand_ready outside HOLD is ignored.
- **Card outputs:** card0..card4 are registered outputs. Values during DRAW are partial and not meaningful. They are valid only while hand_valid=1 and remain stable until the handshake.

## Timing
- **Reset values:**
  - state IDLE, lfsr=LFSR_SEED, used=0, count=0;
  - hand_valid=0, busy=0, card0..card4=6'h00.
- **Async reset mid-DRAW or mid-HOLD:** immediately returns to reset values. No partial hand survives.
- **Start of DRAW:** deal_req sampled at edge E0 → busy=1 after E0.
  - First candidate is evaluated on edge E1, using the lfsr value present after E0.
- **Minimum latency:** five consecutive accepts → hand_valid=1 after E5.
- **Latency growth:** each reject adds one cycle. Latency is unbounded in principle; the bench bounds it empirically.
- **Handshake:** hand_valid falls the cycle after the handshake edge. The earliest next deal_req is sampled one cycle after hand_valid falls.
- **seed_load during DRAW:** the loaded value supplies the candidate on the following edge. Already-inserted cards are kept.
- **Outputs:** busy and hand_valid are decoded from registered state, with no combinational path from inputs.

## Structure
- **Shared package poker_pkg:**
  - typedef card_t {suit[1:0], rank[3:0]};
  - constants RANK_MIN=4'h2, RANK_ACE=4'he, HAND_SIZE=5, LFSR_TAPS=16'hB400;
  - enum dealer_state_t {IDLE, DRAW, HOLD}.
  - The evaluator will use the same card_t.
- **Sub-module hand_lfsr:** clk, rst_n, seed_load, seed → lfsr. It holds the seed-zero substitution.
- **Kept in hand_dealer:** insertion sort, used mask and FSM.

## Test plan
- **Reset:** assert rst_n=0 mid-DRAW → outputs immediately hand_valid=0, busy=0, card0..card4=6'h00. Release → IDLE; first deal uses lfsr=16'hACE1.
- **Golden deal:** seed_load with seed=16'h1234, then deal_req → hand_valid arrives on the exact cycle predicted by the bench LFSR model. All five cards must:
  - match the model;
  - have rank in 2..14;
  - be unique;
  - be ascending by {rank,suit}.
- **Backpressure:** hold hand_ready=0 for 20 cycles in HOLD → hand_valid stays 1 and card0..card4 stay unchanged. hand_ready=1 → IDLE next cycle.
- **Stray requests:**
  - deal_req pulsed during DRAW → no restart; count continues.
  - deal_req coincident with the handshake → no new DRAW.
- **Zero seed:** seed_load with seed=16'h0000 → lfsr=16'hACE1 on the next cycle; the hand equals the reset-seed hand.
- **Soak:** 10,000 hands with random hand_ready → zero duplicates within any hand, zero ranks outside 2..14, and every hand sorted.
